// File: rtl/key_debounce8.sv
// rtl/key_debounce8.sv - two-flop synchroniser and per-key counter debounce for 8 active-low keys
module key_debounce8 #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iKeys,
    input  logic       iEn,
    output logic [7:0] oData,
    output logic       oEI,
    output logic [7:0] oPress,
    output logic [7:0] oRelease,
    output logic       oChange
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1;
    logic [7:0]       sync2;
    logic [CNT_W-1:0] cnt [8];
    logic [7:0]       accept;

    // A key is accepted on the edge its disagreement has persisted for the full count.
    always_comb begin
        accept = '0;
        for (int k = 0; k < 8; k++) begin
            accept[k] = (sync2[k] != oData[k]) && (cnt[k] == CNT_MAX);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            sync1    <= 8'hFF;
            sync2    <= 8'hFF;
            oData    <= 8'hFF;
            oPress   <= '0;
            oRelease <= '0;
            oChange  <= 1'b0;
            oEI      <= 1'b1;
            for (int k = 0; k < 8; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            sync1    <= iKeys;
            sync2    <= sync1;
            oEI      <= ~iEn;
            oData    <= oData ^ accept;
            oPress   <= accept & oData;
            oRelease <= accept & ~oData;
            oChange  <= |accept;
            for (int k = 0; k < 8; k++) begin
                if (sync2[k] == oData[k] || accept[k]) begin
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_key_debounce8.sv
// tb/tb_key_debounce8.sv - vector table, corner sequences and randomized scoreboard for key_debounce8
module tb_key_debounce8;
    localparam int N = 4;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [7:0] iKeys;
    logic       iEn;
    logic [7:0] oData;
    logic       oEI;
    logic [7:0] oPress;
    logic [7:0] oRelease;
    logic       oChange;

    key_debounce8 #(.DEBOUNCE_CYCLES(N)) dut (
        .iClk(iClk), .iRst(iRst), .iKeys(iKeys), .iEn(iEn),
        .oData(oData), .oEI(oEI), .oPress(oPress), .oRelease(oRelease), .oChange(oChange)
    );

    always #5 iClk = ~iClk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] keys;
        logic       en;
        logic       rst;
        logic [7:0] expData;
        logic [7:0] expPress;
        logic [7:0] expRelease;
        logic       expChange;
        logic       expEI;
    } vec_t;
    vec_t vecs[$];

    // Reference: a key level is taken once the last N synchronised samples all disagree with it.
    logic [7:0] mP1, mP2, mStable;
    logic [7:0] mWin[$];
    logic [7:0] ePress, eRel;
    logic       eChg, eEI;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        logic [7:0] acc;
        logic [7:0] w;
        logic       all;
        if (iRst) begin
            mP1 = 8'hFF; mP2 = 8'hFF; mStable = 8'hFF;
            mWin.delete();
            ePress = '0; eRel = '0; eChg = 1'b0; eEI = 1'b1;
        end else begin
            mWin.push_back(mP2);
            if (mWin.size() > N) void'(mWin.pop_front());
            acc = '0;
            if (mWin.size() == N) begin
                for (int k = 0; k < 8; k++) begin
                    all = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        w = mWin[i];
                        if (w[k] == mStable[k]) all = 1'b0;
                    end
                    acc[k] = all;
                end
            end
            ePress  = acc & mStable;
            eRel    = acc & ~mStable;
            eChg    = |acc;
            mStable = mStable ^ acc;
            mP2 = mP1;
            mP1 = iKeys;
            eEI = ~iEn;
        end
    endtask

    task automatic step(input logic [7:0] k, input logic e, input logic r);
        iKeys = k; iEn = e; iRst = r;
        @(posedge iClk);
        modelEdge();
        #1;
        check("mdl_data", 32'(oData), 32'(mStable));
        check("mdl_press", 32'(oPress), 32'(ePress));
        check("mdl_release", 32'(oRelease), 32'(eRel));
        check("mdl_change", 32'(oChange), 32'(eChg));
        check("mdl_ei", 32'(oEI), 32'(eEI));
    endtask

    function automatic void addVec(input logic [7:0] k, input logic r, input logic [7:0] d,
                                   input logic [7:0] p, input logic [7:0] rl, input logic c);
        vec_t v;
        v.keys = k; v.en = 1'b0; v.rst = r; v.expData = d;
        v.expPress = p; v.expRelease = rl; v.expChange = c; v.expEI = 1'b1;
        vecs.push_back(v);
    endfunction

    function automatic void addRun(input logic [7:0] k, input logic r, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) addVec(k, r, d, 8'h00, 8'h00, 1'b0);
    endfunction

    function automatic int topKey(input logic [7:0] d);
        int idx = -1;
        for (int k = 0; k < 8; k++) if (!d[k]) idx = k;
        return idx;
    endfunction

    initial begin
        int at;
        int nChg;
        logic [7:0] evt;
        int hold[8];
        logic [7:0] rk;

        iRst = 1'b1; iKeys = 8'h00; iEn = 1'b0;
        mP1 = 8'hFF; mP2 = 8'hFF; mStable = 8'hFF;
        ePress = '0; eRel = '0; eChg = 1'b0; eEI = 1'b1;

        // Reset with keys low, then all-pressed, all-released, clean press of key 3.
        addRun(8'h00, 1'b1, 8'hFF, 3);
        addRun(8'h00, 1'b0, 8'hFF, 5);
        addVec(8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1);
        addRun(8'h00, 1'b0, 8'h00, 1);
        addRun(8'hFF, 1'b0, 8'h00, 5);
        addVec(8'hFF, 1'b0, 8'hFF, 8'h00, 8'hFF, 1'b1);
        addRun(8'hFF, 1'b0, 8'hFF, 1);
        addRun(8'hF7, 1'b0, 8'hFF, 5);
        addVec(8'hF7, 1'b0, 8'hF7, 8'h08, 8'h00, 1'b1);
        addRun(8'hF7, 1'b0, 8'hF7, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].keys, vecs[i].en, vecs[i].rst);
            check($sformatf("tbl%0d_data", i), 32'(oData), 32'(vecs[i].expData));
            check($sformatf("tbl%0d_press", i), 32'(oPress), 32'(vecs[i].expPress));
            check($sformatf("tbl%0d_release", i), 32'(oRelease), 32'(vecs[i].expRelease));
            check($sformatf("tbl%0d_change", i), 32'(oChange), 32'(vecs[i].expChange));
            check($sformatf("tbl%0d_ei", i), 32'(oEI), 32'(vecs[i].expEI));
        end

        // Bounce on key 3: two-cycle levels never complete the count.
        for (int i = 0; i < 12; i++) begin
            step((i < 8 && (i / 2) % 2 == 0) ? 8'hFF : 8'hF7, 1'b0, 1'b0);
            check("bounce_data", 32'(oData), 32'h0F7);
            check("bounce_pulse", 32'(oPress | oRelease), 32'h0);
        end
        at = -1; evt = '0;
        for (int i = 1; i <= 8; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            if (at < 0 && oData == 8'hFF) begin at = i; evt = oRelease; end
        end
        check("bounce_release_edge", 32'(at), 32'd6);
        check("bounce_release_val", 32'(evt), 32'h08);

        // Two keys on a single edge.
        at = -1; evt = '0; nChg = 0;
        for (int i = 1; i <= 8; i++) begin
            step(8'h7E, 1'b0, 1'b0);
            if (oChange) nChg++;
            if (at < 0 && oData == 8'h7E) begin at = i; evt = oPress; end
        end
        check("multi_edge", 32'(at), 32'd6);
        check("multi_press", 32'(evt), 32'h81);
        check("multi_change_count", 32'(nChg), 32'd1);

        // Reset mid-count, then full latency again.
        for (int i = 0; i < 8; i++) step(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(8'hFE, 1'b0, 1'b0);
        step(8'hFE, 1'b0, 1'b1);
        check("midrst_data", 32'(oData), 32'h0FF);
        check("midrst_pulse", 32'({oPress, oRelease, 7'd0, oChange}), 32'h0);
        at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(8'hFE, 1'b0, 1'b0);
            if (at < 0 && oData == 8'hFE) at = i;
        end
        check("midrst_latency", 32'(at), 32'd6);

        // Enable path follows ~iEn one edge later; downstream sees key 3.
        for (int i = 0; i < 3; i++) begin
            step(8'hF7, 1'b0, 1'b0);
            check("en_low", 32'(oEI), 32'h1);
        end
        step(8'hF7, 1'b1, 1'b0);
        check("en_high", 32'(oEI), 32'h0);
        step(8'hF7, 1'b0, 1'b0);
        check("en_low_again", 32'(oEI), 32'h1);
        for (int i = 0; i < 4; i++) step(8'hF7, 1'b1, 1'b0);
        check("enc_data", 32'(oData), 32'h0F7);
        check("enc_ei", 32'(oEI), 32'h0);
        check("enc_key", 32'(topKey(oData)), 32'd3);

        // Randomized bouncing keys with occasional resets.
        for (int k = 0; k < 8; k++) hold[k] = 0;
        rk = 8'hFF;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (hold[k] == 0) begin
                    rk[k] = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 8);
                end else begin
                    hold[k]--;
                end
            end
            step(rk, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/key_debounce8.md
Name: key_debounce8

Overview:
- Upstream front end for the 8-to-3 priority encoder. Takes 8 raw, active-low mechanical key/switch lines from board pins.
- Synchronises each line to the clock and debounces it with a per-key counter.
- Presents a clean, glitch-free active-low 8-bit vector that connects directly to the encoder's iData, plus enable and event outputs.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised key level must differ from the stable level before it is accepted (10 ms at 100 MHz); legal minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-key counter (derived; not overridden).

Ports:
- iClk  input  1  system clock, rising-edge.
- iRst  input  1  synchronous reset, active-high.
- iKeys  input  8  raw key lines, asynchronous, active-low (0 = pressed).
- iEn  input  1  enable for downstream encoding, active-high.
- oData  output  8  debounced key vector, active-low; feeds the encoder iData.
- oEI  output  1  active-low encoder enable; registered copy of ~iEn, forced 1 during reset.
- oPress  output  8  one-cycle pulse per bit, set when that oData bit falls 1->0.
- oRelease  output  8  one-cycle pulse per bit, set when that oData bit rises 0->1.
- oChange  output  1  one-cycle pulse, OR of oPress and oRelease for that cycle.

Behaviour:
- Reset state: while iRst=1 at a rising edge, all of the following are registered. Global reset overrides everything, including mid-count and mid-pulse.
  - sync1 and sync2 = 8'hFF.
  - oData = 8'hFF.
  - All counters = 0.
  - oPress, oRelease = 0 and oChange = 0.
  - oEI = 1.
- Synchroniser: two flip-flop stages per bit, sync1 <= iKeys and sync2 <= sync1. s = sync2.
- Per-key debounce, evaluated independently for each bit k at every rising edge:
  - If s[k] == oData[k]: cnt[k] <= 0.
  - If s[k] != oData[k] and cnt[k] != DEBOUNCE_CYCLES-1: cnt[k] <= cnt[k]+1.
  - If s[k] != oData[k] and cnt[k] == DEBOUNCE_CYCLES-1: oData[k] <= s[k] and cnt[k] <= 0.
- Latency: a level on iKeys[k] held steady from the edge at which it is first sampled appears on oData[k] after exactly 2 + DEBOUNCE_CYCLES rising edges (2 synchroniser edges plus N counter edges).
- Glitch rejection: any return of s[k] to oData[k] before the count completes clears cnt[k]. No change occurs, and the full count restarts on the next disagreement.
- Event pulses:
  - oPress[k] is registered on the same edge at which oData[k] goes 1->0, and lasts 1 cycle.
  - oRelease[k] behaves the same way for 0->1.
  - oChange = |(oPress|oRelease), also registered.
  - Otherwise all pulse outputs are 0.
  - Simultaneous transitions on several bits at one edge each raise their own bit in the same cycle.
- oEI <= ~iEn every edge; 1-cycle latency; unrelated to key activity.
- Counter saturation: cnt[k] never exceeds DEBOUNCE_CYCLES-1; wrap-around cannot occur.
- No combinational path from any input to any output; all outputs are registered.
- Synthesis target: pure RTL, no vendor primitives.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
1. Reset: iRst=1 for 3 edges with iKeys=8'h00.
   - During reset: oData=8'hFF, oPress/oRelease=0, oChange=0, oEI=1.
   - After release with iKeys held at 00: oData=8'h00 on the 6th edge, and oPress=8'hFF for exactly 1 cycle.
2. Clean press: iKeys 8'hFF -> 8'hF7, held.
   - oData=8'hF7 exactly 6 edges after the first sampling edge.
   - oPress=8'h08 and oChange=1 for 1 cycle; oRelease=0.
3. Bounce: from the stable F7 state, bit 3 toggles 1,0,1,0 with each level held 2 cycles, then stays 0.
   - oData stays 8'hF7 throughout; no pulses.
   - A later 1-level held 4+ cycles gives oData=8'hFF with oRelease=8'h08.
4. Simultaneous keys: iKeys FF -> 7E on a single edge.
   - oData=8'h7E after 6 edges.
   - oPress=8'h81 in one cycle; oChange=1 for one cycle only.
5. Reset mid-count: start a press on bit 0, assert iRst after 3 counting edges.
   - oData=8'hFF and no pulse.
   - After deassert with the key still held, the full 6-edge latency applies again.
6. Enable path: toggle iEn 0->1->0.
   - oEI follows ~iEn with 1-cycle delay, independent of iKeys activity.
   - Encoder downstream reads oData=8'hF7 with oEI=0, giving the code for key 3.
